branch_predict_pc_unit: RTL and testbench

Fetch-PC register plus dynamic branch predictor. It is the next generation of the combinational PC-select logic, parametrised in PC width, offset width and table depth.
- Each cycle it predicts the next fetch PC from a direct-mapped BTB with 2-bit saturating counters.
- Branches resolve later in the pipeline; on a mispredict it raises flush and redirects.
- Sits between the fetch stage and the branch-resolve (EX) stage.

---
 rtl/branch_predict_pc_unit_pkg.sv | 35 +++
 rtl/branch_predict_pc_unit_cond.sv | 31 +++
 rtl/branch_predict_pc_unit.sv | 118 +++++++++++
 tb/tb_branch_predict_pc_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/branch_predict_pc_unit_pkg.sv
// Shared encodings for the fetch-PC / branch predictor slice.
package branch_predict_pc_unit_pkg;

  typedef enum logic [2:0] {
    COND_NE     = 3'b000,
    COND_EQ     = 3'b001,
    COND_GT     = 3'b010,
    COND_LT     = 3'b011,
    COND_GE     = 3'b100,
    COND_LE     = 3'b101,
    COND_OVFL   = 3'b110,
    COND_UNCOND = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    logic [1:0] n;
    n = c;
    if (taken && (c != CTR_ST)) n = c + 2'd1;
    else if (!taken && (c != CTR_SNT)) n = c - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/branch_predict_pc_unit_cond.sv
// Branch condition evaluator: condition code + {N,V,Z} flags -> taken.
module branch_cond_eval
  import branch_predict_pc_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;

  // Decode the condition against the flag bits.
  always_comb begin
    z     = flags[FLAG_Z];
    v     = flags[FLAG_V];
    n     = flags[FLAG_N];
    taken = 1'b0;
    case (cond_e'(cond))
      COND_NE:     taken = ~z;
      COND_EQ:     taken = z;
      COND_GT:     taken = ~z & ~n;
      COND_LT:     taken = n;
      COND_GE:     taken = z | (~z & ~n);
      COND_LE:     taken = n | z;
      COND_OVFL:   taken = v;
      COND_UNCOND: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_pc_unit.sv
// Fetch-PC register with a direct-mapped BTB and 2-bit counter predictor;
// resolves branches from EX, flushes and redirects on a mispredict.
module branch_predict_pc_unit
  import branch_predict_pc_unit_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     IMM_W    = 9,
  parameter int unsigned     DEPTH    = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [PC_W-1:0]  pc_out,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             res_valid,
  input  logic [PC_W-1:0]  res_pc_inc,
  input  logic [2:0]       res_cond,
  input  logic [IMM_W-1:0] res_imm,
  input  logic [2:0]       res_flags,
  input  logic             res_br,
  input  logic [PC_W-1:0]  res_rs,
  input  logic             res_pred_taken,
  input  logic [PC_W-1:0]  res_pred_target,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = PC_W - IDX_W - 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             valid_q [DEPTH];
  logic             valid_d [DEPTH];
  logic [1:0]       ctr_q   [DEPTH];
  logic [1:0]       ctr_d   [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [TAG_W-1:0] tag_d   [DEPTH];
  logic [PC_W-1:0]  tgt_q   [DEPTH];
  logic [PC_W-1:0]  tgt_d   [DEPTH];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic [PC_W-1:0]  br_pc, imm_ext, act_tgt;
  logic             taken, hit, mispredict;
  logic             unused_ok;

  branch_cond_eval u_cond (
    .cond  (res_cond),
    .flags (res_flags),
    .taken (taken)
  );

  assign pc_out    = pc_q;
  assign unused_ok = ^{br_pc[0], pc_q[0]};

  // Fetch-side lookup of the entry addressed by the current PC.
  always_comb begin
    f_idx       = pc_q[IDX_W:1];
    f_tag       = pc_q[PC_W-1:IDX_W+1];
    hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = hit & ctr_q[f_idx][1];
    pred_target = tgt_q[f_idx];
  end

  // Resolve the branch in EX and compare against what was predicted.
  always_comb begin
    imm_ext     = PC_W'($signed(res_imm));
    act_tgt     = res_br ? res_rs : (res_pc_inc + (imm_ext << 1));
    mispredict  = (taken != res_pred_taken) || (taken && (act_tgt != res_pred_target));
    flush       = res_valid & mispredict & ~rst;
    redirect_pc = taken ? act_tgt : res_pc_inc;
  end

  // Next PC and table update; the fetch lookup above reads the old entries.
  always_comb begin
    br_pc   = res_pc_inc - PC_W'(2);
    u_idx   = br_pc[IDX_W:1];
    u_tag   = br_pc[PC_W-1:IDX_W+1];
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (res_valid) begin
      ctr_d[u_idx] = ctr_next(ctr_q[u_idx], taken);
      if (taken) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = act_tgt;
      end
    end
    if (flush)           pc_d = redirect_pc;
    else if (stall)      pc_d = pc_q;
    else if (pred_taken) pc_d = pred_target;
    else                 pc_d = pc_q + PC_W'(2);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_pc_unit.sv
// Directed bench for branch_predict_pc_unit with a queue of expected PCs.
module tb_branch_predict_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [15:0] pc_out, pred_target, redirect_pc;
  logic        pred_taken, flush;
  logic        res_valid, res_br, res_pred_taken;
  logic [15:0] res_pc_inc, res_rs, res_pred_target;
  logic [2:0]  res_cond, res_flags;
  logic [8:0]  res_imm;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [15:0] exp_q[$];

  branch_predict_pc_unit #(.PC_W(16), .IMM_W(9), .DEPTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_out(pc_out),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc_inc(res_pc_inc), .res_cond(res_cond),
    .res_imm(res_imm), .res_flags(res_flags), .res_br(res_br), .res_rs(res_rs),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .flush(flush), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expected next PC, clock once, drop res_valid, compare PC.
  task automatic tick(input logic [15:0] e);
    logic [15:0] want;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    want = exp_q.pop_front();
    check("pc_out", {16'h0, pc_out}, {16'h0, want});
    #1;
  endtask

  task automatic resolve(input logic [15:0] inc, input logic [2:0] cond, input logic [2:0] flg,
                         input logic [8:0] imm, input logic br, input logic [15:0] rs,
                         input logic ptk, input logic [15:0] ptgt);
    res_valid = 1'b1; res_pc_inc = inc; res_cond = cond; res_flags = flg;
    res_imm = imm; res_br = br; res_rs = rs; res_pred_taken = ptk; res_pred_target = ptgt;
    #1;
  endtask

  // Force fetch to an address via a mispredicted register branch at 0x00FE.
  task automatic goto_pc(input logic [15:0] t);
    resolve(16'h0100, 3'b111, 3'b000, 9'h000, 1'b1, t, 1'b0, 16'h0000);
    check("goto_flush", {31'h0, flush}, 32'h1);
    check("goto_redir", {16'h0, redirect_pc}, {16'h0, t});
    tick(t);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    res_valid = 1'b0; res_pc_inc = '0; res_cond = '0; res_imm = '0; res_flags = '0;
    res_br = 1'b0; res_rs = '0; res_pred_taken = 1'b0; res_pred_target = '0;
    #12 rst = 1'b0;
    #1;
    // 1: reset state and sequential fetch
    check("rst_pc", {16'h0, pc_out}, 32'h0);
    check("rst_pred", {31'h0, pred_taken}, 32'h0);
    check("rst_flush", {31'h0, flush}, 32'h0);
    tick(16'h0002);
    tick(16'h0004);

    // 2: BEQ at 0x0010 taken, predicted not-taken
    goto_pc(16'h0010);
    resolve(16'h0012, 3'b001, 3'b001, 9'h004, 1'b0, 16'h0000, 1'b0, 16'h0000);
    check("t2_old_pred", {31'h0, pred_taken}, 32'h0);
    check("t2_flush", {31'h0, flush}, 32'h1);
    check("t2_redir", {16'h0, redirect_pc}, 32'h001A);
    tick(16'h001A);
    goto_pc(16'h0010);
    check("t2_pred", {31'h0, pred_taken}, 32'h1);
    check("t2_ptgt", {16'h0, pred_target}, 32'h001A);
    tick(16'h001A);

    // 3: same branch not taken while predicted taken
    resolve(16'h0012, 3'b001, 3'b000, 9'h004, 1'b0, 16'h0000, 1'b1, 16'h001A);
    check("t3_flush", {31'h0, flush}, 32'h1);
    check("t3_redir", {16'h0, redirect_pc}, 32'h0012);
    tick(16'h0012);
    goto_pc(16'h0010);
    check("t3_pred", {31'h0, pred_taken}, 32'h0);
    tick(16'h0012);

    // 4: register branch with wrong predicted target
    resolve(16'h0024, 3'b111, 3'b000, 9'h000, 1'b1, 16'h1234, 1'b1, 16'h2000);
    check("t4_flush", {31'h0, flush}, 32'h1);
    check("t4_redir", {16'h0, redirect_pc}, 32'h1234);
    tick(16'h1234);
    goto_pc(16'h0022);
    check("t4_pred", {31'h0, pred_taken}, 32'h1);
    check("t4_ptgt", {16'h0, pred_target}, 32'h1234);
    tick(16'h1234);

    // 5: flush overrides stall, then stall holds
    stall = 1'b1;
    goto_pc(16'h0040);
    for (int i = 0; i < 3; i++) tick(16'h0040);
    stall = 1'b0;

    // 6a: PC wrap
    goto_pc(16'hFFFE);
    check("wrap_pred", {31'h0, pred_taken}, 32'h0);
    tick(16'h0000);

    // 6b: counter saturation on branch at 0x0044
    for (int i = 0; i < 4; i++) begin
      resolve(16'h0046, 3'b111, 3'b000, 9'h000, 1'b0, 16'h0000, 1'b1, 16'h0046);
      check("sat_flush", {31'h0, flush}, 32'h0);
      tick(16'(2 * (i + 1)));
    end
    resolve(16'h0046, 3'b000, 3'b001, 9'h000, 1'b0, 16'h0000, 1'b1, 16'h0046);
    check("sat_nt_flush", {31'h0, flush}, 32'h1);
    check("sat_nt_redir", {16'h0, redirect_pc}, 32'h0046);
    tick(16'h0046);
    goto_pc(16'h0044);
    check("sat_pred_st", {31'h0, pred_taken}, 32'h1);
    check("sat_ptgt", {16'h0, pred_target}, 32'h0046);
    tick(16'h0046);
    resolve(16'h0046, 3'b000, 3'b001, 9'h000, 1'b0, 16'h0000, 1'b1, 16'h0046);
    tick(16'h0046);
    goto_pc(16'h0044);
    check("sat_pred_wnt", {31'h0, pred_taken}, 32'h0);
    tick(16'h0046);

    // 6c: asynchronous reset mid-run
    goto_pc(16'h0022);
    check("pre_rst_pred", {31'h0, pred_taken}, 32'h1);
    resolve(16'h0100, 3'b111, 3'b000, 9'h000, 1'b1, 16'h0080, 1'b0, 16'h0000);
    rst = 1'b1;
    #1;
    check("mid_rst_pc", {16'h0, pc_out}, 32'h0);
    check("mid_rst_flush", {31'h0, flush}, 32'h0);
    check("mid_rst_pred", {31'h0, pred_taken}, 32'h0);
    @(posedge clk);
    #1;
    check("mid_rst_hold", {16'h0, pc_out}, 32'h0);
    rst = 1'b0; res_valid = 1'b0;
    #1;
    check("post_rst_pc", {16'h0, pc_out}, 32'h0);
    goto_pc(16'h0022);
    check("post_rst_pred", {31'h0, pred_taken}, 32'h0);
    tick(16'h0024);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
